pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the RV32I 5-stage pipeline. It drives the enables of the PC, IF/ID, ID/EX and EX/MEM registers and the bubble-insert (flush) selects for IF/ID, ID/EX and MEM/WB. It resolves load-use hazards, taken branches and jumps, instruction/data memory wait states, boot fill and halt drain. The IF/ID register holds 0x00000000 after reset, which is not a NOP, so this block's flush outputs select NOP 0x00000013 into each stage's D input.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/hazard_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Brief    : Shared constants for the RV32I pipeline hazard sequencer.
//  Revision : 1.0
// ============================================================================
package pipeline_pkg;

    localparam int          REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [2:0] state_t;

    localparam state_t S_BOOT   = 3'd0;
    localparam state_t S_RUN    = 3'd1;
    localparam state_t S_DWAIT  = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_HALTED = 3'd4;

endpackage
`default_nettype wire

// File: rtl/hazard_load_use_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hazard_load_use_detect
//  Brief    : Flags an ID instruction reading the destination of a load in EX.
//  Revision : 1.0
// ============================================================================
module hazard_load_use_detect
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 rd_is_load,
    output logic                 hazard
);

    logic w_rd_live;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rd_live = rd_is_load && (rd != '0);
    assign hazard    = w_rd_live && ((rd == rs1) || (rd == rs2));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for the 5-stage pipeline (boot, hazards,
//             memory waits, halt drain). Optional perf counters are enabled
//             with the HAZARD_PERF_CNT_EN macro.
//  Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int BOOT_CYCLES   = 2,
    parameter int DWAIT_TIMEOUT = 255,
    parameter int DRAIN_CYCLES  = 4
)
(
    input  logic                 clk_I,
    input  logic                 reset_I,
    input  logic [REG_IDX_W-1:0] idRs1_I,
    input  logic [REG_IDX_W-1:0] idRs2_I,
    input  logic [REG_IDX_W-1:0] exRd_I,
    input  logic                 exMemRead_I,
    input  logic                 exBranchTaken_I,
    input  logic                 memAccess_I,
    input  logic                 dmemReady_I,
    input  logic                 imemReady_I,
    input  logic                 haltReq_I,
    output logic                 pcEnable_O,
    output logic                 pcSelTarget_O,
    output logic                 ifIdEnable_O,
    output logic                 ifIdFlush_O,
    output logic                 idExEnable_O,
    output logic                 idExFlush_O,
    output logic                 exMemEnable_O,
    output logic                 memWbFlush_O,
    output logic                 halted_O,
    output logic                 busErr_O
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stallCycles_O,
    output logic [31:0]          flushCount_O
`endif
);

    localparam int BOOT_W  = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES)  : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [BOOT_W-1:0]  r_boot_cnt;
    logic [7:0]         r_wait_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_bus_err;

    logic w_load_use;
    logic w_mem_stall;
    logic w_wait;
    logic w_at_limit;
    logic w_timeout;
    logic w_drain_adv;
    logic w_branch_flush;

    hazard_load_use_detect u_load_use (
        .rs1        (idRs1_I),
        .rs2        (idRs2_I),
        .rd         (exRd_I),
        .rd_is_load (exMemRead_I),
        .hazard     (w_load_use)
    );

    assign w_mem_stall = memAccess_I && !dmemReady_I;
    assign w_at_limit  = (r_wait_cnt == 8'(DWAIT_TIMEOUT));
    assign w_timeout   = w_wait && w_at_limit;
    assign busErr_O    = r_bus_err;

    always_comb begin
        pcEnable_O     = 1'b0;
        pcSelTarget_O  = 1'b0;
        ifIdEnable_O   = 1'b0;
        ifIdFlush_O    = 1'b0;
        idExEnable_O   = 1'b0;
        idExFlush_O    = 1'b0;
        exMemEnable_O  = 1'b0;
        memWbFlush_O   = 1'b0;
        halted_O       = 1'b0;
        w_next_state   = r_state;
        w_wait         = 1'b0;
        w_drain_adv    = 1'b0;
        w_branch_flush = 1'b0;

        case (r_state)
            S_BOOT: begin
                ifIdFlush_O  = 1'b1;
                idExFlush_O  = 1'b1;
                memWbFlush_O = 1'b1;
                if (r_boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
                    w_next_state = S_RUN;
                end
            end

            S_RUN: begin
                pcEnable_O    = 1'b1;
                ifIdEnable_O  = 1'b1;
                idExEnable_O  = 1'b1;
                exMemEnable_O = 1'b1;
                if (w_mem_stall) begin
                    pcEnable_O    = 1'b0;
                    ifIdEnable_O  = 1'b0;
                    idExEnable_O  = 1'b0;
                    exMemEnable_O = 1'b0;
                    memWbFlush_O  = 1'b1;
                    w_wait        = 1'b1;
                    w_next_state  = S_DWAIT;
                end else if (exBranchTaken_I) begin
                    // Younger instructions are wrong-path, so their hazards and halts are moot
                    pcSelTarget_O  = 1'b1;
                    ifIdFlush_O    = 1'b1;
                    idExFlush_O    = 1'b1;
                    w_branch_flush = 1'b1;
                end else if (w_load_use) begin
                    pcEnable_O   = 1'b0;
                    ifIdEnable_O = 1'b0;
                    idExFlush_O  = 1'b1;
                end else if (!imemReady_I) begin
                    pcEnable_O  = 1'b0;
                    ifIdFlush_O = 1'b1;
                end else if (haltReq_I) begin
                    pcEnable_O   = 1'b0;
                    ifIdFlush_O  = 1'b1;
                    w_next_state = S_DRAIN;
                end
            end

            S_DWAIT: begin
                if (dmemReady_I) begin
                    pcEnable_O    = 1'b1;
                    ifIdEnable_O  = 1'b1;
                    idExEnable_O  = 1'b1;
                    exMemEnable_O = 1'b1;
                    w_next_state  = S_RUN;
                end else begin
                    memWbFlush_O = 1'b1;
                    w_wait       = 1'b1;
                    if (w_at_limit) begin
                        w_next_state = S_HALTED;
                    end
                end
            end

            S_DRAIN: begin
                if (w_mem_stall) begin
                    memWbFlush_O = 1'b1;
                    w_wait       = 1'b1;
                    if (w_at_limit) begin
                        w_next_state = S_HALTED;
                    end
                end else begin
                    ifIdEnable_O  = 1'b1;
                    ifIdFlush_O   = 1'b1;
                    idExEnable_O  = 1'b1;
                    exMemEnable_O = 1'b1;
                    w_drain_adv   = 1'b1;
                    if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        w_next_state = S_HALTED;
                    end
                end
            end

            S_HALTED: begin
                ifIdFlush_O  = 1'b1;
                idExFlush_O  = 1'b1;
                memWbFlush_O = 1'b1;
                halted_O     = 1'b1;
            end

            default: begin
                ifIdFlush_O  = 1'b1;
                idExFlush_O  = 1'b1;
                memWbFlush_O = 1'b1;
                w_next_state = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            r_state     <= S_BOOT;
            r_boot_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_BOOT) begin
                r_boot_cnt <= r_boot_cnt + 1'b1;
            end else begin
                r_boot_cnt <= '0;
            end

            // Counts consecutive wait cycles, including the one that left S_RUN
            if (w_wait) begin
                r_wait_cnt <= w_at_limit ? r_wait_cnt : r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (r_state != S_DRAIN) begin
                r_drain_cnt <= '0;
            end else if (w_drain_adv) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_stall_cycle;

    assign w_stall_cycle = ((r_state == S_RUN) || (r_state == S_DWAIT)) && !pcEnable_O;
    assign stallCycles_O = r_stall_cycles;
    assign flushCount_O  = r_flush_count;

    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_cycle) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_branch_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Directed and randomized checks of pipeline_hazard_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int BOOT_CYCLES   = 2;
    localparam int DWAIT_TIMEOUT = 255;
    localparam int DRAIN_CYCLES  = 4;

    // {pcEn, pcSel, ifIdEn, ifIdFl, idExEn, idExFl, exMemEn, memWbFl, halted, busErr}
    localparam logic [9:0] BOOT_VEC     = 10'b0001010100;
    localparam logic [9:0] RUN_VEC      = 10'b1010101000;
    localparam logic [9:0] LU_VEC       = 10'b0000111000;
    localparam logic [9:0] BR_VEC       = 10'b1111111000;
    localparam logic [9:0] WAIT_VEC     = 10'b0000000100;
    localparam logic [9:0] FETCH_HOLD   = 10'b0011101000;
    localparam logic [9:0] HALT_VEC     = 10'b0001010110;
    localparam logic [9:0] HALT_ERR_VEC = 10'b0001010111;

    logic       clk_I = 1'b0;
    logic       reset_I;
    logic [4:0] idRs1_I, idRs2_I, exRd_I;
    logic       exMemRead_I, exBranchTaken_I, memAccess_I, dmemReady_I, imemReady_I, haltReq_I;
    logic       pcEnable_O, pcSelTarget_O, ifIdEnable_O, ifIdFlush_O, idExEnable_O;
    logic       idExFlush_O, exMemEnable_O, memWbFlush_O, halted_O, busErr_O;
    logic [9:0] outs;

    always #5 clk_I = ~clk_I;

    pipeline_hazard_ctrl #(
        .BOOT_CYCLES   (BOOT_CYCLES),
        .DWAIT_TIMEOUT (DWAIT_TIMEOUT),
        .DRAIN_CYCLES  (DRAIN_CYCLES)
    ) dut (
        .clk_I           (clk_I),
        .reset_I         (reset_I),
        .idRs1_I         (idRs1_I),
        .idRs2_I         (idRs2_I),
        .exRd_I          (exRd_I),
        .exMemRead_I     (exMemRead_I),
        .exBranchTaken_I (exBranchTaken_I),
        .memAccess_I     (memAccess_I),
        .dmemReady_I     (dmemReady_I),
        .imemReady_I     (imemReady_I),
        .haltReq_I       (haltReq_I),
        .pcEnable_O      (pcEnable_O),
        .pcSelTarget_O   (pcSelTarget_O),
        .ifIdEnable_O    (ifIdEnable_O),
        .ifIdFlush_O     (ifIdFlush_O),
        .idExEnable_O    (idExEnable_O),
        .idExFlush_O     (idExFlush_O),
        .exMemEnable_O   (exMemEnable_O),
        .memWbFlush_O    (memWbFlush_O),
        .halted_O        (halted_O),
        .busErr_O        (busErr_O)
    );

    assign outs = {pcEnable_O, pcSelTarget_O, ifIdEnable_O, ifIdFlush_O, idExEnable_O,
                   idExFlush_O, exMemEnable_O, memWbFlush_O, halted_O, busErr_O};

    typedef enum int {M_BOOT, M_RUN, M_WAIT, M_DRAIN, M_HALT} mode_t;
    mode_t m_mode;
    int    m_boot_done;
    int    m_waits;
    int    m_drained;
    bit    m_err;
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic bit load_use();
        return exMemRead_I && (exRd_I != 5'd0) && (exRd_I == idRs1_I || exRd_I == idRs2_I);
    endfunction

    function automatic logic [9:0] model_out();
        logic pe = 0, ps = 0, fe = 0, ff = 0, de = 0, df = 0, me = 0, wf = 0, h = 0;
        bit dstall = memAccess_I && !dmemReady_I;
        case (m_mode)
            M_BOOT: begin ff = 1; df = 1; wf = 1; end
            M_HALT: begin ff = 1; df = 1; wf = 1; h = 1; end
            M_WAIT: if (dmemReady_I) begin pe = 1; fe = 1; de = 1; me = 1; end else wf = 1;
            M_DRAIN: if (dstall) wf = 1; else begin fe = 1; de = 1; me = 1; ff = 1; end
            M_RUN: begin
                pe = 1; fe = 1; de = 1; me = 1;
                if (dstall)              begin pe = 0; fe = 0; de = 0; me = 0; wf = 1; end
                else if (exBranchTaken_I) begin ps = 1; ff = 1; df = 1; end
                else if (load_use())      begin pe = 0; fe = 0; df = 1; end
                else if (!imemReady_I)    begin pe = 0; ff = 1; end
                else if (haltReq_I)       begin pe = 0; ff = 1; end
            end
            default: ;
        endcase
        return {pe, ps, fe, ff, de, df, me, wf, h, m_err};
    endfunction

    task automatic model_reset();
        m_mode = M_BOOT; m_boot_done = 0; m_waits = 0; m_drained = 0; m_err = 0;
    endtask

    // One wait cycle too many trips the bus error; the wait leaving S_RUN counts too
    task automatic note_wait();
        m_waits++;
        if (m_waits > DWAIT_TIMEOUT) begin m_err = 1; m_mode = M_HALT; end
    endtask

    task automatic model_step();
        bit dstall = memAccess_I && !dmemReady_I;
        case (m_mode)
            M_BOOT: begin
                m_boot_done++;
                if (m_boot_done == BOOT_CYCLES) m_mode = M_RUN;
            end
            M_RUN: begin
                if (dstall) begin m_waits = 1; m_mode = M_WAIT; end
                else if (!exBranchTaken_I && !load_use() && imemReady_I && haltReq_I) begin
                    m_mode = M_DRAIN; m_drained = 0;
                end
            end
            M_WAIT: begin
                if (dmemReady_I) begin m_waits = 0; m_mode = M_RUN; end
                else note_wait();
            end
            M_DRAIN: begin
                if (dstall) note_wait();
                else begin
                    m_waits = 0;
                    m_drained++;
                    if (m_drained == DRAIN_CYCLES) m_mode = M_HALT;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    endtask

    task automatic run_cycle(input string tag, input bit use_want, input logic [9:0] want);
        #1;
        if (use_want) check(tag, outs, want);
        check({tag, "/model"}, outs, model_out());
        @(posedge clk_I);
        model_step();
        @(negedge clk_I);
    endtask

    task automatic tick(input string tag);
        run_cycle(tag, 1'b0, 10'd0);
    endtask

    task automatic tick_want(input string tag, input logic [9:0] want);
        run_cycle(tag, 1'b1, want);
    endtask

    // Reset drops between edges to confirm the outputs follow it without a clock
    task automatic do_reset(input string tag);
        #2 reset_I = 1'b0;
        #1 check(tag, outs, BOOT_VEC);
        model_reset();
        @(negedge clk_I);
        reset_I = 1'b1;
    endtask

    task automatic clear_inputs();
        idRs1_I = '0; idRs2_I = '0; exRd_I = '0;
        exMemRead_I = 0; exBranchTaken_I = 0; memAccess_I = 0;
        dmemReady_I = 1; imemReady_I = 1; haltReq_I = 0;
    endtask

    task automatic boot_to_run(input string tag);
        tick_want({tag, "_boot0"}, BOOT_VEC);
        tick_want({tag, "_boot1"}, BOOT_VEC);
        tick_want({tag, "_run"}, RUN_VEC);
    endtask

    initial begin
        clear_inputs();
        reset_I = 1'b0;
        model_reset();
        @(negedge clk_I);
        check("reset_hold", outs, BOOT_VEC);
        reset_I = 1'b1;
        boot_to_run("t1");

        exMemRead_I = 1; exRd_I = 5'd5; idRs2_I = 5'd5; idRs1_I = 5'd3;
        tick_want("load_use_rs2", LU_VEC);
        exMemRead_I = 0;
        tick_want("load_use_one_bubble", RUN_VEC);
        exMemRead_I = 1; exRd_I = 5'd0; idRs1_I = 5'd0; idRs2_I = 5'd0;
        tick_want("load_use_x0", RUN_VEC);
        exRd_I = 5'd9; idRs1_I = 5'd9;
        tick_want("load_use_rs1", LU_VEC);

        exRd_I = 5'd5; idRs1_I = 5'd3; idRs2_I = 5'd5; exBranchTaken_I = 1; haltReq_I = 1;
        tick_want("branch_over_lu", BR_VEC);
        clear_inputs();
        tick_want("halt_dropped_on_branch", RUN_VEC);
        imemReady_I = 0;
        tick_want("imem_miss", FETCH_HOLD);
        imemReady_I = 1;

        memAccess_I = 1; dmemReady_I = 0;
        repeat (3) tick_want("dwait3", WAIT_VEC);
        dmemReady_I = 1;
        tick_want("dwait_resume", RUN_VEC);
        memAccess_I = 0;
        tick_want("after_dwait", RUN_VEC);

        haltReq_I = 1;
        tick_want("halt_req", FETCH_HOLD);
        haltReq_I = 0;
        repeat (DRAIN_CYCLES) tick_want("drain", FETCH_HOLD);
        tick_want("halted", HALT_VEC);
        haltReq_I = 1;
        tick_want("halted_stays", HALT_VEC);
        haltReq_I = 0;

        do_reset("reset_from_halt");
        boot_to_run("t5b");
        haltReq_I = 1;
        tick_want("halt_req2", FETCH_HOLD);
        haltReq_I = 0;
        tick_want("drain_adv1", FETCH_HOLD);
        memAccess_I = 1; dmemReady_I = 0;
        repeat (2) tick_want("drain_wait", WAIT_VEC);
        memAccess_I = 0; dmemReady_I = 1;
        repeat (DRAIN_CYCLES - 1) tick_want("drain_adv", FETCH_HOLD);
        tick_want("halted_after_6", HALT_VEC);

        do_reset("reset_before_timeout");
        boot_to_run("t4b");
        memAccess_I = 1; dmemReady_I = 0;
        tick_want("timeout_first", WAIT_VEC);
        repeat (DWAIT_TIMEOUT) tick("timeout_wait");
        tick_want("timeout_halt", HALT_ERR_VEC);
        memAccess_I = 0; dmemReady_I = 1;
        tick_want("bus_err_sticky", HALT_ERR_VEC);

        do_reset("reset_clears_err");
        boot_to_run("t6a");
        memAccess_I = 1; dmemReady_I = 0;
        tick_want("pre_reset_wait0", WAIT_VEC);
        tick_want("pre_reset_wait1", WAIT_VEC);
        do_reset("reset_mid_dwait");
        clear_inputs();
        boot_to_run("t6b");

        for (int i = 0; i < 1500; i++) begin
            idRs1_I         = 5'($urandom_range(0, 7));
            idRs2_I         = 5'($urandom_range(0, 7));
            exRd_I          = 5'($urandom_range(0, 7));
            exMemRead_I     = ($urandom_range(0, 1) == 0);
            exBranchTaken_I = ($urandom_range(0, 7) == 0);
            memAccess_I     = ($urandom_range(0, 2) == 0);
            dmemReady_I     = ($urandom_range(0, 3) != 0);
            imemReady_I     = ($urandom_range(0, 7) != 0);
            haltReq_I       = ($urandom_range(0, 15) == 0);
            tick("random");
            if ((m_mode == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                do_reset("random_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
